cci_mpf_prim_ram_dualport_byteena_fwd: RTL



---
 rtl/cci_mpf_prim_ram_dualport_byteena_fwd.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cci_mpf_prim_ram_dualport_byteena_fwd.sv
// ---------------------------------------------------------------------------
// cci_mpf_prim_ram_dualport_byteena_fwd
//
// Single-clock, true dual-port, byte-masked RAM with reset-time
// initialization, read-valid tracking, optional output pipelining, and
// deterministic NEW_DATA semantics on both ports:
//   - a read returns, per byte, the data written in the same cycle by either
//     port to that address, otherwise the stored byte;
//   - when both ports write the same byte of the same address in one cycle,
//     the priority port (PORT1_WRITE_PRIORITY) supplies the byte.
//
// Ports (port 1 mirrors port 0):
//   clk0      clock for both ports
//   reset     synchronous, active-high
//   rdy       high once initialization is done; stays high until reset
//   addrN     address (entries >= N_ENTRIES: writes dropped, reads return 0)
//   wenN      write enable; byteenaN selects the bytes written from wdataN
//   rdenN     read request
//   rdataN    read data, qualified by rvalidN
//   rvalidN   high N_OUTPUT_REG_STAGES+1 cycles after an accepted rdenN
//
// Handshake: rdenN is fire-and-forget with no ready/backpressure. Each
// accepted request (rdenN=1 while rdy=1) yields exactly one cycle of
// rvalidN=1, in request order; the consumer must take rdataN on that cycle.
// Requests and writes presented while rdy=0 are ignored.
//
// The init FSM has two states; rdy is the direct decode of RUN, so the FSM
// state is always observable on rdy.
// ---------------------------------------------------------------------------
module cci_mpf_prim_ram_dualport_byteena_fwd #(
  parameter int N_ENTRIES = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_BYTE_BITS = 8,
  parameter int N_OUTPUT_REG_STAGES = 0,
  parameter int INIT_ENABLE = 1,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE = N_DATA_BITS'(0),
  parameter int PORT1_WRITE_PRIORITY = 1,
  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
  localparam int NB = N_DATA_BITS / N_BYTE_BITS
) (
  input  logic                   clk0,
  input  logic                   reset,
  output logic                   rdy,

  input  logic [AW-1:0]          addr0,
  input  logic                   wen0,
  input  logic [NB-1:0]          byteena0,
  input  logic [N_DATA_BITS-1:0] wdata0,
  input  logic                   rden0,
  output logic [N_DATA_BITS-1:0] rdata0,
  output logic                   rvalid0,

  input  logic [AW-1:0]          addr1,
  input  logic                   wen1,
  input  logic [NB-1:0]          byteena1,
  input  logic [N_DATA_BITS-1:0] wdata1,
  input  logic                   rden1,
  output logic [N_DATA_BITS-1:0] rdata1,
  output logic                   rvalid1
);

  localparam int S = N_OUTPUT_REG_STAGES;
  localparam logic [AW:0] N_ENT = (AW+1)'(N_ENTRIES);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_ENTRIES - 1);
  localparam bit P1_HI = (PORT1_WRITE_PRIORITY != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_q;
  logic [AW-1:0]   init_idx_q;

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  // ---------------------------------------------------------------------
  // Init FSM: walks every entry once after reset, then parks in RUN.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else if (state_q == ST_INIT) begin
      // Leave INIT in the same cycle the last entry is written, so rdy
      // rises exactly N_ENTRIES cycles after reset drops.
      if ((INIT_ENABLE == 0) || (init_idx_q == LAST_IDX)) begin
        state_q <= ST_RUN;
      end else begin
        init_idx_q <= init_idx_q + 1'b1;
      end
    end
  end

  assign rdy = (state_q == ST_RUN);

  logic init_we;
  logic run;
  logic ok0, ok1;

  // Gating on reset keeps a request in the reset-assert cycle from landing.
  assign init_we = ~reset & (state_q == ST_INIT) & (INIT_ENABLE != 0);
  assign run     = ~reset & (state_q == ST_RUN);
  assign ok0     = ({1'b0, addr0} < N_ENT);
  assign ok1     = ({1'b0, addr1} < N_ENT);

  // Per-byte effective write enables, already qualified by rdy and range.
  logic [NB-1:0] we0_b, we1_b;
  assign we0_b = (run & wen0 & ok0) ? byteena0 : '0;
  assign we1_b = (run & wen1 & ok1) ? byteena1 : '0;

  // Recast the two ports as low/high priority so the merge below is a
  // single ordered overlay: high-priority bytes are applied last.
  logic [NB-1:0]          lo_we, hi_we;
  logic [AW-1:0]          lo_addr, hi_addr;
  logic [N_DATA_BITS-1:0] lo_data, hi_data;

  assign lo_we   = P1_HI ? we0_b  : we1_b;
  assign lo_addr = P1_HI ? addr0  : addr1;
  assign lo_data = P1_HI ? wdata0 : wdata1;
  assign hi_we   = P1_HI ? we1_b  : we0_b;
  assign hi_addr = P1_HI ? addr1  : addr0;
  assign hi_data = P1_HI ? wdata1 : wdata0;

  // ---------------------------------------------------------------------
  // Post-write word at each port's address: stored word with this cycle's
  // writes from both ports overlaid. It is both the forwarded read result
  // and the value written back, so reads and storage always agree.
  // ---------------------------------------------------------------------
  logic [N_DATA_BITS-1:0] new0, new1;

  always_comb begin
    new0 = ok0 ? mem[addr0] : '0;
    new1 = ok1 ? mem[addr1] : '0;
    for (int b = 0; b < NB; b++) begin
      if (lo_we[b] && (lo_addr == addr0)) new0[b*N_BYTE_BITS +: N_BYTE_BITS] = lo_data[b*N_BYTE_BITS +: N_BYTE_BITS];
      if (hi_we[b] && (hi_addr == addr0)) new0[b*N_BYTE_BITS +: N_BYTE_BITS] = hi_data[b*N_BYTE_BITS +: N_BYTE_BITS];
      if (lo_we[b] && (lo_addr == addr1)) new1[b*N_BYTE_BITS +: N_BYTE_BITS] = lo_data[b*N_BYTE_BITS +: N_BYTE_BITS];
      if (hi_we[b] && (hi_addr == addr1)) new1[b*N_BYTE_BITS +: N_BYTE_BITS] = hi_data[b*N_BYTE_BITS +: N_BYTE_BITS];
    end
  end

  // Whole-word write-back. When both ports hit the same address, new0 and
  // new1 are identical merged words, so the double write is harmless.
  always_ff @(posedge clk0) begin
    if (init_we) begin
      mem[init_idx_q] <= INIT_VALUE;
    end
    if (|we0_b) begin
      mem[addr0] <= new0;
    end
    if (|we1_b) begin
      mem[addr1] <= new1;
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline: stage 0 is the RAM read stage, stages 1..S are the
  // optional output registers. Data and valid travel together.
  // ---------------------------------------------------------------------
  logic                        rd0, rd1;
  logic [S:0]                  rvalid0_q, rvalid1_q;
  logic [S:0][N_DATA_BITS-1:0] rdata0_q, rdata1_q;

  assign rd0 = run & rden0;
  assign rd1 = run & rden1;

  always_ff @(posedge clk0) begin
    if (reset) begin
      rvalid0_q <= '0;
      rvalid1_q <= '0;
    end else begin
      rvalid0_q[0] <= rd0;
      rvalid1_q[0] <= rd1;
      for (int s = 1; s <= S; s++) begin
        rvalid0_q[s] <= rvalid0_q[s-1];
        rvalid1_q[s] <= rvalid1_q[s-1];
      end
    end
  end

  // Data registers need no reset: rdata is only meaningful with rvalid.
  always_ff @(posedge clk0) begin
    if (rd0) rdata0_q[0] <= new0;
    if (rd1) rdata1_q[0] <= new1;
    for (int s = 1; s <= S; s++) begin
      if (rvalid0_q[s-1]) rdata0_q[s] <= rdata0_q[s-1];
      if (rvalid1_q[s-1]) rdata1_q[s] <= rdata1_q[s-1];
    end
  end

  assign rdata0  = rdata0_q[S];
  assign rvalid0 = rvalid0_q[S];
  assign rdata1  = rdata1_q[S];
  assign rvalid1 = rvalid1_q[S];

endmodule
